fifo_burst_writer: RTL and testbench

- Programmable write-side stimulus engine for the asynchronous FIFO; lives in the write clock domain and drives the FIFO's wr_en / data_in pins.
- Generates N bursts of L words each, with G idle cycles between bursts, and honours full back-pressure.
- Supplies a deterministic data pattern so the read side can check the stream word for word.

---
 rtl/fifo_burst_writer_if.sv | 11 +
 rtl/fifo_burst_writer.sv | 224 ++++++++++++++++++++++
 tb/tb_fifo_burst_writer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_writer_if.sv
// FIFO write-port bundle between the burst writer (master) and the FIFO (slave).
interface fifo_burst_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;

  modport master (output wr_en, output wr_data, input full);
  modport slave  (input wr_en, input wr_data, output full);
endinterface

// File: rtl/fifo_burst_writer.sv
// Write-side stimulus engine for the asynchronous FIFO: issues num_bursts bursts
// of burst_len words with idle_len idle cycles between them, stalls on full and
// produces an incrementing or LFSR data pattern so the reader can check it.
// Optional feature macro: FIFO_BURST_WRITER_LFSR_EN builds the LFSR pattern
// generator; without it mode is ignored and the increment pattern is always used.
module fifo_burst_writer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    LEN_WIDTH  = 8,
  parameter int                    CNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = DATA_WIDTH'(8'hA5)
) (
  input  logic                   clk_wr,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode,
  input  logic [LEN_WIDTH-1:0]   burst_len,
  input  logic [LEN_WIDTH-1:0]   idle_len,
  input  logic [LEN_WIDTH-1:0]   num_bursts,
  fifo_burst_writer_if.master    fifo,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   words_written
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  burst_len_q, burst_len_d;
  logic [LEN_WIDTH-1:0]  idle_len_q, idle_len_d;
  logic [LEN_WIDTH-1:0]  num_bursts_q, num_bursts_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;
  logic [LEN_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  last_beat;
  logic                  last_burst;
  logic                  gap_end;
  logic [DATA_WIDTH-1:0] pattern_next;
  logic [DATA_WIDTH-1:0] pattern_start;

  assign last_beat  = (beat_cnt_q  == burst_len_q  - LEN_WIDTH'(1));
  assign last_burst = (burst_cnt_q == num_bursts_q - LEN_WIDTH'(1));
  assign gap_end    = (gap_cnt_q   == idle_len_q   - LEN_WIDTH'(1));

`ifdef FIFO_BURST_WRITER_LFSR_EN
  // Right-shifting Galois feedback masks; bit k set means x^(k+1) is a tap.
  // Unlisted widths fall back to x^N + x^(N-1) + 1, which is not maximal length
  // but is still invertible, so a nonzero seed never reaches zero.
  function automatic logic [DATA_WIDTH-1:0] lfsr_taps(input int width);
    logic [63:0] t;
    case (width)
      4:       t = 64'h0000_000C;
      8:       t = 64'h0000_00B8;
      16:      t = 64'h0000_B400;
      32:      t = 64'h8020_0003;
      default: t = 64'h3 << (width - 2);
    endcase
    return DATA_WIDTH'(t);
  endfunction

  localparam logic [DATA_WIDTH-1:0] LFSR_TAPS = lfsr_taps(DATA_WIDTH);

  logic mode_q, mode_d;

  // Next pattern word for the mode latched at start.
  always_comb begin
    if (mode_q) begin
      pattern_next = (pattern_q >> 1) ^ (pattern_q[0] ? LFSR_TAPS : '0);
    end else begin
      pattern_next = pattern_q + DATA_WIDTH'(1);
    end
  end

  assign pattern_start = mode ? LFSR_SEED : '0;
`else
  // Without the LFSR only the increment pattern exists.
  assign pattern_next  = pattern_q + DATA_WIDTH'(1);
  assign pattern_start = '0;

  logic unused_cfg;
  assign unused_cfg = mode ^ (^LFSR_SEED);
`endif

  // FSM state register, plus the registered busy flag that tracks it.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // FSM next-state logic; abort outranks every other transition.
  // NOTE: each always_comb assigns defaults first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (burst_len == '0 || num_bursts == '0) state_d = S_DONE;
            else                                     state_d = S_BURST;
          end
        end
        S_BURST: begin
          if (accept && last_beat) begin
            if (last_burst)              state_d = S_DONE;
            else if (idle_len_q == '0)   state_d = S_BURST;
            else                         state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (gap_end) state_d = S_BURST;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // FSM outputs; wr_en follows full combinationally so a stall costs no cycle.
  always_comb begin
    accept       = (state_q == S_BURST) && !fifo.full && !abort;
    fifo.wr_en   = accept;
    fifo.wr_data = pattern_q;
    done         = (state_q == S_DONE) && !abort;
  end

  assign busy          = busy_q;
  assign words_written = words_q;

  // Datapath: latch the run configuration at start, then advance the pattern
  // and counters only on accepted writes or idle gap cycles.
  always_comb begin
    burst_len_d  = burst_len_q;
    idle_len_d   = idle_len_q;
    num_bursts_d = num_bursts_q;
    beat_cnt_d   = beat_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    pattern_d    = pattern_q;
    words_d      = words_q;
`ifdef FIFO_BURST_WRITER_LFSR_EN
    mode_d       = mode_q;
`endif
    if (state_q == S_IDLE) begin
      if (start) begin
        burst_len_d  = burst_len;
        idle_len_d   = idle_len;
        num_bursts_d = num_bursts;
        beat_cnt_d   = '0;
        burst_cnt_d  = '0;
        gap_cnt_d    = '0;
        pattern_d    = pattern_start;
        words_d      = '0;
`ifdef FIFO_BURST_WRITER_LFSR_EN
        mode_d       = mode;
`endif
      end
    end else if (accept) begin
      pattern_d = pattern_next;
      words_d   = words_q + CNT_WIDTH'(1);
      if (last_beat) begin
        beat_cnt_d  = '0;
        burst_cnt_d = burst_cnt_q + LEN_WIDTH'(1);
      end else begin
        beat_cnt_d  = beat_cnt_q + LEN_WIDTH'(1);
      end
    end else if (state_q == S_GAP && !abort) begin
      gap_cnt_d = gap_end ? '0 : gap_cnt_q + LEN_WIDTH'(1);
    end
  end

  // Datapath registers; everything clears on reset so wr_data reads 0.
  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      burst_len_q  <= '0;
      idle_len_q   <= '0;
      num_bursts_q <= '0;
      beat_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      pattern_q    <= '0;
      words_q      <= '0;
    end else begin
      burst_len_q  <= burst_len_d;
      idle_len_q   <= idle_len_d;
      num_bursts_q <= num_bursts_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      pattern_q    <= pattern_d;
      words_q      <= words_d;
    end
  end

`ifdef FIFO_BURST_WRITER_LFSR_EN
  // Latched pattern mode.
  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) mode_q <= 1'b0;
    else        mode_q <= mode_d;
  end
`endif

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Self-checking bench for fifo_burst_writer: directed runs from the test plan
// plus randomized runs, all checked cycle by cycle against a run-level model.
module tb_fifo_burst_writer;

  logic       clk_wr = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic       abort  = 1'b0;
  logic       mode   = 1'b0;
  logic [7:0] burst_len  = '0;
  logic [7:0] idle_len   = '0;
  logic [7:0] num_bursts = '0;
  logic       busy;
  logic       done;
  logic [15:0] words_written;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] seen[$];

  fifo_burst_writer_if #(.DATA_WIDTH(8)) fifo_if ();

  fifo_burst_writer #(
    .DATA_WIDTH(8),
    .LEN_WIDTH (8),
    .CNT_WIDTH (16),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk_wr       (clk_wr),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .mode         (mode),
    .burst_len    (burst_len),
    .idle_len     (idle_len),
    .num_bursts   (num_bursts),
    .fifo         (fifo_if),
    .busy         (busy),
    .done         (done),
    .words_written(words_written)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

`ifdef FIFO_BURST_WRITER_LFSR_EN
  // x^8 + x^6 + x^5 + x^4 + 1 in right-shifting Galois form.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction
`endif

  // One run: the model tracks words accepted so far and idle cycles still owed.
  // full is forced high inside [full_lo, full_hi] (cycle 0 = start cycle) and
  // randomly with probability full_pct percent; abort fires when abort_at words
  // have been accepted (abort_at < 0 disables it).
  task automatic run(input logic m, input int len, input int gap, input int nb,
                     input int full_lo, input int full_hi, input int full_pct,
                     input int abort_at);
    int total = (len == 0 || nb == 0) ? 0 : len * nb;
    int words = 0;
    int gap_left = 0;
    int cyc = 0;
    int budget = 40 + 4 * (total + gap * nb);
    bit finished = 0;
    bit aborted = 0;
    bit in_burst;
    bit use_lfsr = 0;
    logic [7:0] lfsr_word = 8'hA5;
    logic [7:0] exp_word;
`ifdef FIFO_BURST_WRITER_LFSR_EN
    use_lfsr = m;
`endif
    seen.delete();
    @(posedge clk_wr); #1;
    start = 1'b1; mode = m;
    burst_len = 8'(len); idle_len = 8'(gap); num_bursts = 8'(nb);
    fifo_if.full = 1'b0; abort = 1'b0;
    @(negedge clk_wr);
    check("idle_busy_at_start", busy, 0);
    @(posedge clk_wr); #1;
    start = 1'b0;
    burst_len = 8'($urandom); idle_len = 8'($urandom); num_bursts = 8'($urandom);
    while (!finished) begin
      cyc++;
      if (cyc > budget) begin
        check("run_timeout", 1, 0);
        break;
      end
      fifo_if.full = (cyc >= full_lo && cyc <= full_hi) ||
                     ($urandom_range(99) < 32'(full_pct));
      in_burst = (gap_left == 0) && (words < total);
      abort = (abort_at >= 0) && in_burst && (words == abort_at);
      if (cyc > 1 && $urandom_range(3) == 0) start = 1'b1;
      @(negedge clk_wr);
      check("busy", busy, 1);
      check("words_written", words_written, words);
      exp_word = use_lfsr ? lfsr_word : 8'(words);
      if (abort) begin
        check("abort_wr_en", fifo_if.wr_en, 0);
        check("abort_done", done, 0);
        finished = 1;
        aborted = 1;
      end else if (gap_left > 0) begin
        check("gap_wr_en", fifo_if.wr_en, 0);
        check("gap_done", done, 0);
        gap_left--;
      end else if (in_burst) begin
        check("burst_wr_en", fifo_if.wr_en, {31'b0, ~fifo_if.full});
        check("wr_data", fifo_if.wr_data, exp_word);
        check("burst_done", done, 0);
        if (use_lfsr) check("lfsr_nonzero", fifo_if.wr_data != 8'h00, 1);
        if (!fifo_if.full) begin
          seen.push_back(fifo_if.wr_data);
          words++;
`ifdef FIFO_BURST_WRITER_LFSR_EN
          lfsr_word = lfsr_step(lfsr_word);
`endif
          if (words % len == 0 && words < total) gap_left = gap;
        end
      end else begin
        check("done_pulse", done, 1);
        check("done_wr_en", fifo_if.wr_en, 0);
        finished = 1;
      end
      @(posedge clk_wr); #1;
      start = 1'b0;
    end
    abort = 1'b0;
    fifo_if.full = 1'b0;
    @(negedge clk_wr);
    check("end_busy", busy, 0);
    check("end_done", done, 0);
    check("end_wr_en", fifo_if.wr_en, 0);
    check("end_words", words_written, aborted ? abort_at : total);
  endtask

  task automatic reset_mid_run();
    @(posedge clk_wr); #1;
    start = 1'b1; mode = 1'b0; burst_len = 8'd16; idle_len = 8'd0; num_bursts = 8'd1;
    fifo_if.full = 1'b0;
    @(posedge clk_wr); #1;
    start = 1'b0;
    repeat (3) @(posedge clk_wr);
    #1;
    check("rst_pre_wr_en", fifo_if.wr_en, 1);
    check("rst_pre_words", words_written, 3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_en", fifo_if.wr_en, 0);
    check("rst_wr_data", fifo_if.wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_words", words_written, 0);
    @(negedge clk_wr);
    @(negedge clk_wr);
    rst_n = 1'b1;
    @(negedge clk_wr);
    check("post_rst_wr_en", fifo_if.wr_en, 0);
    check("post_rst_busy", busy, 0);
  endtask

  initial begin
    int len, gap, nb, tot, ab;
    fifo_if.full = 1'b0;
    repeat (2) @(negedge clk_wr);
    check("reset_wr_en", fifo_if.wr_en, 0);
    check("reset_wr_data", fifo_if.wr_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_words", words_written, 0);
    rst_n = 1'b1;

    // Incrementing stream, three bursts of four with two idle cycles.
    run(1'b0, 4, 2, 3, -1, -1, 0, -1);
    // Back-pressure during cycles 3..5 of a single 8-word burst.
    run(1'b0, 8, 0, 1, 3, 5, 0, -1);
    check("bp_count", seen.size(), 8);
    // Zero-length runs.
    run(1'b0, 4, 1, 0, -1, -1, 0, -1);
    run(1'b0, 0, 1, 2, -1, -1, 0, -1);
    // Back-to-back bursts crossing the 8-bit data wrap.
    run(1'b0, 200, 0, 2, -1, -1, 0, -1);
    check("wrap_count", seen.size(), 400);
    check("wrap_ff", seen[255], 8'hFF);
    check("wrap_00", seen[256], 8'h00);
    // Abort after five words, then a fresh run restarts at 0.
    run(1'b0, 16, 0, 1, -1, -1, 0, 5);
    run(1'b0, 4, 0, 1, -1, -1, 0, -1);
    check("restart_first", seen[0], 8'h00);
    reset_mid_run();
`ifdef FIFO_BURST_WRITER_LFSR_EN
    run(1'b1, 3, 0, 1, -1, -1, 0, -1);
    check("lfsr_w0", seen[0], 8'hA5);
    check("lfsr_w1", seen[1], 8'hEA);
    check("lfsr_w2", seen[2], 8'h75);
`endif
    // Randomized runs with back-pressure and occasional aborts.
    for (int i = 0; i < 14; i++) begin
      len = $urandom_range(20);
      gap = $urandom_range(4);
      nb  = $urandom_range(4);
      tot = (len == 0 || nb == 0) ? 0 : len * nb;
      ab  = (tot > 0 && $urandom_range(3) == 0) ? $urandom_range(tot - 1) : -1;
      run(1'($urandom_range(1)), len, gap, nb, -1, -1, 30, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
